// File: rtl/pc_unit.sv
// pc_unit: program-counter sequencer with a small branch-target lookup table.
//
// A three-state FSM (IDLE / RUN / HALT) owns the fetch address. In RUN the next
// PC is chosen by priority:
//   1. halt_req -- go to HALT, hold the PC.
//   2. stall    -- hold the PC and taken.
//   3. branch   -- jump_en && flag, load lut[lut_idx].
//   4. increment, wrapping modulo 2^PC_W.
// The LUT is written in any FSM state.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start                begin/restart execution (from IDLE or HALT; ignored in RUN)
//   halt_req, stall      halt / hold requests for the current instruction
//   jump_en, flag        conditional branch and its ALU condition
//   lut_idx              branch-target read index
//   lut_we/waddr/wdata   branch-target write port
//   prog_ctr             registered fetch address
//   taken                registered, set when a branch was taken on the previous edge
//   running, done        registered, set in RUN and HALT respectively
module pc_unit #(
  parameter  int PC_W      = 12,
  parameter  int LUT_DEPTH = 16,
  localparam int IDX_W     = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             jump_en,
  input  logic             flag,
  input  logic [IDX_W-1:0] lut_idx,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             taken,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              taken_nxt;
  logic [PC_W-1:0]   lut [LUT_DEPTH];

  // The LUT read here sees the pre-edge contents, so a same-cycle write to the
  // branch index only becomes visible to later branches.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    taken_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (stall) begin
          taken_nxt = taken;
        end else if (jump_en && flag) begin
          pc_nxt    = lut[lut_idx];
          taken_nxt = 1'b1;
        end else begin
          pc_nxt = prog_ctr + 1'b1;
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // running/done are registered from the next state so they line up with the
  // state register without any decode after the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      taken    <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        lut[i[IDX_W-1:0]] <= '0;
      end
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      taken    <= taken_nxt;
      running  <= (state_nxt == RUN);
      done     <= (state_nxt == HALT);
      if (lut_we) begin
        lut[lut_waddr] <= lut_wdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a table of input/expected-output records
// applied one per clock, followed by hand-written multi-cycle sequences.
module tb_pc_unit;

  localparam int PC_W  = 12;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, halt_req, stall, jump_en, flag, lut_we;
  logic [IDX_W-1:0] lut_idx, lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             taken, running, done;

  pc_unit #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .stall(stall), .jump_en(jump_en), .flag(flag), .lut_idx(lut_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .taken(taken), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst, st, hlt, stl, jmp, flg;
    logic [IDX_W-1:0] idx;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [PC_W-1:0]  wdata;
    logic [PC_W-1:0]  e_pc;
    logic             e_tk, e_run, e_done;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  int applied = 0;
  int errors  = 0;

  function automatic vec_t mk(input logic rst, st, hlt, stl, jmp, flg,
                              input logic [IDX_W-1:0] idx, input logic we,
                              input logic [IDX_W-1:0] waddr, input logic [PC_W-1:0] wdata,
                              input logic [PC_W-1:0] e_pc, input logic e_tk, e_run, e_done);
    vec_t v;
    v = '{rst, st, hlt, stl, jmp, flg, idx, we, waddr, wdata, e_pc, e_tk, e_run, e_done};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; start = v.st; halt_req = v.hlt; stall = v.stl;
    jump_en = v.jmp; flag = v.flg; lut_idx = v.idx; lut_we = v.we;
    lut_waddr = v.waddr; lut_wdata = v.wdata;
  endtask

  task automatic check(input string name, input logic [PC_W-1:0] e_pc,
                       input logic e_tk, e_run, e_done);
    applied++;
    if (prog_ctr !== e_pc || taken !== e_tk || running !== e_run || done !== e_done) begin
      errors++;
      $display("FAIL %s: got pc=%03h taken=%b running=%b done=%b, want pc=%03h taken=%b running=%b done=%b",
               name, prog_ctr, taken, running, done, e_pc, e_tk, e_run, e_done);
    end
  endtask

  initial begin
    logic [PC_W-1:0] m_pc;
    vec_t idle_v;
    //              rst st hlt stl jmp flg idx  we wa   wdata     pc      tk run done
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 1, 0, 0, 4'd0, 1, 4'd5, 12'h123, 12'h000, 0, 0, 0); // reset beats start/we
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd3, 12'h0A0, 12'h001, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 12'h033, 12'h002, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd4, 12'hFFF, 12'h003, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd1, 12'h010, 12'h004, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 1, 4'd6, 12'h007, 12'h005, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h006, 0, 1, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h007, 0, 1, 0); // start ignored in RUN
    vecs[11] = mk(0, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 12'h000, 12'h0A0, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h0A0, 1, 1, 0); // stall holds taken
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h0A1, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 1, 4'd6, 0, 4'd0, 12'h000, 12'h007, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 0, 4'd3, 0, 4'd0, 12'h000, 12'h008, 0, 1, 0); // flag=0
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 4'd3, 0, 4'd0, 12'h000, 12'h009, 0, 1, 0); // flag w/o jump_en
    vecs[17] = mk(0, 0, 0, 0, 1, 1, 4'd5, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0); // write under reset lost
    vecs[18] = mk(0, 0, 0, 0, 1, 1, 4'd1, 0, 4'd0, 12'h000, 12'h010, 1, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 1, 1, 4'd3, 0, 4'd0, 12'h000, 12'h010, 1, 1, 0); // stall beats branch
    vecs[20] = mk(0, 0, 1, 1, 1, 1, 4'd3, 0, 4'd0, 12'h000, 12'h010, 0, 0, 1); // halt beats all
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 12'h000, 12'h010, 0, 0, 1); // HALT holds
    vecs[22] = mk(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 1, 0); // restart
    vecs[23] = mk(0, 0, 0, 0, 1, 1, 4'd4, 0, 4'd0, 12'h000, 12'hFFF, 1, 1, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 1, 0); // wrap
    vecs[25] = mk(0, 0, 0, 0, 1, 1, 4'd2, 1, 4'd2, 12'h055, 12'h033, 1, 1, 0); // old entry
    vecs[26] = mk(0, 0, 0, 0, 1, 1, 4'd2, 0, 4'd0, 12'h000, 12'h055, 1, 1, 0); // new entry
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h056, 0, 1, 0);
    vecs[28] = mk(1, 0, 1, 1, 1, 1, 4'd2, 1, 4'd7, 12'h0AB, 12'h000, 0, 0, 0); // mid-RUN reset
    vecs[29] = mk(0, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 1, 0);
    vecs[30] = mk(0, 0, 0, 0, 1, 1, 4'd3, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0); // LUT cleared
    vecs[31] = mk(0, 0, 0, 0, 1, 1, 4'd7, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0);
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h001, 0, 1, 0);
    vecs[33] = mk(0, 0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h001, 0, 0, 1);
    vecs[34] = mk(1, 1, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 0, 0); // mid-HALT reset
    vecs[35] = mk(0, 0, 1, 0, 1, 1, 4'd2, 0, 4'd0, 12'h000, 12'h000, 0, 0, 0); // IDLE ignores these

    idle_v = mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 12'h000, 12'h000, 0, 0, 0);
    drive(vecs[0]);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_tk, vecs[i].e_run, vecs[i].e_done);
    end

    // Intermittent stalls over a long run: PC advances only on non-stall cycles.
    @(negedge clk);
    drive(idle_v);
    start = 1'b1;
    @(posedge clk); #1;
    check("restart", 12'h000, 0, 1, 0);
    m_pc = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(idle_v);
      stall = (i % 3 == 0);
      @(posedge clk); #1;
      if (!(i % 3 == 0)) m_pc = m_pc + 1'b1;
      check($sformatf("stallseq%0d", i), m_pc, 0, 1, 0);
    end

    // Outputs must not respond to inputs between edges.
    @(negedge clk);
    reset = 1'b1; halt_req = 1'b1; jump_en = 1'b1; flag = 1'b1; lut_idx = 4'd4;
    #2;
    check("no_comb_path", m_pc, 0, 1, 0);
    @(posedge clk); #1;
    check("final_reset", 12'h000, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule
